// File: rtl/prog_loader.sv
// Program loader: parses a length-prefixed, XOR-checksummed byte stream and
// writes 32-bit words into program memory while holding the core in reset.
module prog_loader #(
   parameter int SIZE_LOG2 = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 WE,
   output logic [SIZE_LOG2-1:0] WA,
   output logic [31:0]          WD,
   output logic                 cpu_rst,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [2:0]           state_dbg
);

   // Byte stream: a byte moves on any cycle where in_valid and in_ready are both
   // high; in_ready is a pure decode of state, so it never depends on in_valid.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [32:0]        MAX_WORDS = 33'd1 << SIZE_LOG2;
   localparam logic [SIZE_LOG2:0] ONE       = {{SIZE_LOG2{1'b0}}, 1'b1};

   state_t               state, state_nx;
   logic [1:0]           byte_cnt;
   logic [SIZE_LOG2:0]   word_cnt;
   logic [SIZE_LOG2:0]   word_total;
   logic [SIZE_LOG2:0]   word_next;
   logic [31:0]          shreg;
   logic [31:0]          full_word;
   logic [7:0]           acc;
   logic                 xfer;
   logic                 last_byte;
   logic                 restart;

   assign xfer      = in_valid & in_ready;
   assign last_byte = (byte_cnt == 2'd3);
   // Little-endian assembly: each new byte enters at the top and shifts down,
   // so the first byte of a group ends up in bits 7:0.
   assign full_word = {in_data, shreg[31:8]};
   assign word_next = word_cnt + ONE;
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      cpu_rst  = 1'b0;
      restart  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_HDR;
               restart  = 1'b1;
            end
         end
         S_HDR: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            cpu_rst  = 1'b1;
            if (xfer && last_byte) begin
               if ({1'b0, full_word} > MAX_WORDS) state_nx = S_ERR;
               else if (full_word == 32'd0)       state_nx = S_CSUM;
               else                               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            cpu_rst  = 1'b1;
            if (xfer && last_byte && (word_next == word_total)) state_nx = S_CSUM;
         end
         S_CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            cpu_rst  = 1'b1;
            if (xfer) state_nx = (in_data == acc) ? S_DONE : S_ERR;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               state_nx = S_HDR;
               restart  = 1'b1;
            end
         end
         S_ERR: begin
            err     = 1'b1;
            cpu_rst = 1'b1;
            if (start) begin
               state_nx = S_HDR;
               restart  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // WE/WA/WD are registered from the byte that completes a word, so a byte
   // accepted during the WE pulse only touches shreg and cannot disturb WD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt   <= 2'd0;
         word_cnt   <= '0;
         word_total <= '0;
         shreg      <= 32'd0;
         acc        <= 8'd0;
         WE         <= 1'b0;
         WA         <= '0;
         WD         <= 32'd0;
      end else begin
         WE <= 1'b0;
         if (restart) begin
            byte_cnt   <= 2'd0;
            word_cnt   <= '0;
            word_total <= '0;
            shreg      <= 32'd0;
            acc        <= 8'd0;
         end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= full_word;
            case (state)
               S_HDR: begin
                  if (last_byte) word_total <= full_word[SIZE_LOG2:0];
               end
               S_DATA: begin
                  acc <= acc ^ in_data;
                  if (last_byte) begin
                     WE       <= 1'b1;
                     WA       <= word_cnt[SIZE_LOG2-1:0];
                     WD       <= full_word;
                     word_cnt <= word_next;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
